// File: rtl/regfile_wr_arb_pkg.sv
// Shared CPU writeback constants: default port widths, requester indices
// and the saturating increment used by the conflict counter.
package regfile_wr_arb_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int AW_DEF    = 4;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/regfile_wr_arb_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last-granted
// requester and moves only when a grant is issued.
module rr_arb2
    import regfile_wr_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic       last_q;
    logic       last_d;
    logic [1:0] gnt_raw;

    always_comb begin
        gnt_raw = req_i;
        if (req_i[0] && req_i[1]) begin
            // Tie goes to whoever did not win last time.
            gnt_raw = (last_q == REQ_MEM) ? 2'b01 : 2'b10;
        end
    end

    // Grants are forced low while reset is held so neither requester sees ready.
    assign gnt_o = reset ? gnt_raw : 2'b00;

    always_comb begin
        last_d = last_q;
        if (gnt_raw[0]) begin
            last_d = REQ_ALU;
        end else if (gnt_raw[1]) begin
            last_d = REQ_MEM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= REQ_MEM;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter: two writeback requesters share one
// write port through a round-robin grant and a single registered stage.
module regfile_wr_arb
    import regfile_wr_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic [7:0]       conflict_cnt
);

    logic [1:0]       gnt;
    logic             wr_en_q,   wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [7:0]       cnt_q,     cnt_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Address and data hold their last values when no grant is issued.
    always_comb begin
        wr_en_d   = |gnt;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (gnt[0]) begin
            wr_addr_d = req0_addr;
            wr_data_d = req0_data;
        end else if (gnt[1]) begin
            wr_addr_d = req1_addr;
            wr_data_d = req1_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (req0_valid && req1_valid) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cnt_q     <= 8'd0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Bench for regfile_wr_arb: vector table plus hand-written reset,
// saturation and same-address sequences, checked through an expected queue.
module tb_regfile_wr_arb;

    localparam int WIDTH = 16;
    localparam int AW    = 4;

    logic             clk;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic [AW-1:0]    req0_addr,  req1_addr;
    logic [WIDTH-1:0] req0_data,  req1_data;
    logic             req0_ready, req1_ready;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [7:0]       conflict_cnt;

    regfile_wr_arb #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .conflict_cnt (conflict_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             v0;
        logic [AW-1:0]    a0;
        logic [WIDTH-1:0] d0;
        logic             v1;
        logic [AW-1:0]    a1;
        logic [WIDTH-1:0] d1;
        logic             r0;
        logic             r1;
    } vec_t;

    vec_t tbl[13];

    logic [AW+WIDTH-1:0] exp_q[$];
    logic [AW+WIDTH-1:0] hold;
    logic [7:0]          m_cnt;
    int                  total_cnt;
    int                  pass_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after a rising edge: compares the registered write stage.
    task automatic check_out(input logic granted);
        logic [AW+WIDTH-1:0] item;
        if (granted) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'd0, 32'd1);
            end else begin
                item = exp_q.pop_front();
                chk("wr_en_pulse", {31'd0, wr_en}, 32'd1);
                chk("wr_addr_data", {12'd0, wr_addr, wr_data}, {12'd0, item});
                hold = item;
            end
        end else begin
            chk("wr_en_idle", {31'd0, wr_en}, 32'd0);
            chk("wr_hold", {12'd0, wr_addr, wr_data}, {12'd0, hold});
        end
        chk("conflict_cnt", {24'd0, conflict_cnt}, {24'd0, m_cnt});
    endtask

    // Driver: applies one cycle of requests, checks readys mid-cycle.
    task automatic drive_cycle(input logic v0, input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1,
                               input logic er0, input logic er1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #2;
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, er0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, er1});
        if (er0) exp_q.push_back({a0, d0});
        else if (er1) exp_q.push_back({a1, d1});
        if (v0 && v1 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        @(posedge clk);
        #1;
        check_out(er0 || er1);
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Holds reset with both requesters valid, then releases just after an edge.
    task automatic do_reset();
        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd6; req0_data = 16'hAAAA;
        req1_valid = 1'b1; req1_addr = 4'd8; req1_data = 16'hBBBB;
        #2;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr_data", {12'd0, wr_addr, wr_data}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_cnt", {24'd0, conflict_cnt}, 32'd0);
        chk("rst_wr_en_edge", {31'd0, wr_en}, 32'd0);
        exp_q.delete();
        hold  = '0;
        m_cnt = 8'd0;
        reset = 1'b1;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        m_cnt     = 8'd0;
        hold      = '0;

        tbl[0]  = '{1'b1, 4'd1, 16'h0011, 1'b1, 4'd2, 16'h0022, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 4'd1, 16'h0011, 1'b1, 4'd2, 16'h0022, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 4'd1, 16'h0011, 1'b1, 4'd2, 16'h0022, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 4'd1, 16'h0011, 1'b1, 4'd2, 16'h0022, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'd9, 16'h1234, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 4'd4, 16'h0044, 1'b1, 4'd5, 16'h0055, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 4'd4, 16'h0044, 1'b1, 4'd5, 16'h0055, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd12, 16'hC0DE, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 4'd15, 16'hFFFF, 1'b1, 4'd14, 16'h7777, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive_cycle(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1,
                        tbl[i].r0, tbl[i].r1);
            if (i == 3) chk("contention_cnt", {24'd0, conflict_cnt}, 32'd4);
        end

        // Saturation: ties alternate starting with requester 0 after reset.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'b1, 4'(i), 16'(i), 1'b1, 4'(i + 1), 16'(i + 1000),
                        (i % 2) == 0, (i % 2) == 1);
        end
        chk("sat_cnt", {24'd0, conflict_cnt}, 32'd255);
        idle_cycle();
        chk("sat_hold", {24'd0, conflict_cnt}, 32'd255);

        // Mid-operation reset discards the accepted write.
        do_reset();
        req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 16'h5555;
        req1_valid = 1'b0;
        #2;
        chk("mid_ready0", {31'd0, req0_ready}, 32'd1);
        #1;
        reset = 1'b0;
        req0_valid = 1'b0;
        #1;
        chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_addr", {28'd0, wr_addr}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_post_wr_en", {31'd0, wr_en}, 32'd0);
        chk("mid_post_addr", {28'd0, wr_addr}, 32'd0);

        // Same-address tie: requester 0 data lands first, then requester 1.
        do_reset();
        drive_cycle(1'b1, 4'd7, 16'h0001, 1'b1, 4'd7, 16'h0002, 1'b1, 1'b0);
        drive_cycle(1'b1, 4'd7, 16'h0001, 1'b1, 4'd7, 16'h0002, 1'b0, 1'b1);
        idle_cycle();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
